tx_trn_arbiter: RTL

- Shares the single TRN transmit interface of the PCIe endpoint among N_REQ TLP-generating engines (read-request generator, completion/write engines).
- Engines use the my_turn / driving_interface handshake: an engine samples my_turn, raises driving_interface, sends its TLP, then drops it.
- This block rotates my_turn round-robin, muxes the owner's TRN transmit signals to the core, and flags protocol violations.
- trn_tdst_rdy_n, trn_tbuf_av and cfg_completer_id fan out to the engines outside this block.

---
 rtl/tx_trn_arbiter_pkg.sv | 20 ++
 rtl/trn_tx_mux.sv | 46 ++++
 rtl/tx_trn_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tx_trn_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_trn_arbiter_pkg : TRN idle values and arbiter state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package tx_trn_arbiter_pkg;

    localparam logic [63:0] TRN_TD_IDLE   = 64'h0;
    localparam logic [7:0]  TRN_TREM_IDLE = 8'hFF;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        OFFER = 4'b0010,
        GUARD = 4'b0100,
        BUSY  = 4'b1000
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/trn_tx_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trn_tx_mux : selects one requester's TRN transmit fields, idle when disabled
// Revision: 1.0
// ---------------------------------------------------------------------------
module trn_tx_mux #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic                 en,
    input  logic [PTR_W-1:0]     sel,
    input  logic [64*N_REQ-1:0]  req_td,
    input  logic [8*N_REQ-1:0]   req_trem_n,
    input  logic [N_REQ-1:0]     req_tsof_n,
    input  logic [N_REQ-1:0]     req_teof_n,
    input  logic [N_REQ-1:0]     req_tsrc_rdy_n,
    output logic [63:0]          trn_td,
    output logic [7:0]           trn_trem_n,
    output logic                 trn_tsof_n,
    output logic                 trn_teof_n,
    output logic                 trn_tsrc_rdy_n
);
    import tx_trn_arbiter_pkg::*;

    always_comb begin
        trn_td         = TRN_TD_IDLE;
        trn_trem_n     = TRN_TREM_IDLE;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        if (en) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (sel == PTR_W'(i)) begin
                    trn_td         = req_td[64*i +: 64];
                    trn_trem_n     = req_trem_n[8*i +: 8];
                    trn_tsof_n     = req_tsof_n[i];
                    trn_teof_n     = req_teof_n[i];
                    trn_tsrc_rdy_n = req_tsrc_rdy_n[i];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tx_trn_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_trn_arbiter : round-robin my_turn/driving_interface arbiter for TRN TX
// Revision: 1.0
// ---------------------------------------------------------------------------
module tx_trn_arbiter #(
    parameter int N_REQ        = 3,
    parameter int OFFER_CYCLES = 4,
    parameter int BUSY_TIMEOUT = 1024,
    localparam int PTR_W       = $clog2(N_REQ)
) (
    input  logic                 trn_clk,
    input  logic                 reset_n,
    input  logic [64*N_REQ-1:0]  req_td,
    input  logic [8*N_REQ-1:0]   req_trem_n,
    input  logic [N_REQ-1:0]     req_tsof_n,
    input  logic [N_REQ-1:0]     req_teof_n,
    input  logic [N_REQ-1:0]     req_tsrc_rdy_n,
    input  logic [N_REQ-1:0]     driving_interface,
    output logic [N_REQ-1:0]     my_turn,
    output logic [63:0]          trn_td,
    output logic [7:0]           trn_trem_n,
    output logic                 trn_tsof_n,
    output logic                 trn_teof_n,
    output logic                 trn_tsrc_rdy_n,
    output logic [PTR_W-1:0]     owner_idx,
    output logic                 proto_err,
    output logic                 busy_to_err
);
    import tx_trn_arbiter_pkg::*;

    localparam logic [7:0]       C_OFFER_LAST = 8'(OFFER_CYCLES - 1);
    localparam logic [31:0]      C_BUSY_LAST  = 32'(BUSY_TIMEOUT - 1);
    localparam logic [N_REQ-1:0] C_ONE        = N_REQ'(1);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  my_turn_q, my_turn_d;
    logic [7:0]        offer_cnt_q, offer_cnt_d;
    logic [31:0]       busy_cnt_q, busy_cnt_d;
    logic              proto_err_q, proto_err_d;
    logic              busy_to_err_q, busy_to_err_d;

    logic [PTR_W-1:0]  w_ptr_next;
    logic              w_own;
    logic              w_timeout;
    logic              w_proto_bad;

    assign w_ptr_next  = (ptr_q == PTR_W'(N_REQ - 1)) ? '0 : ptr_q + 1'b1;
    assign w_own       = driving_interface[ptr_q];
    assign w_timeout   = (BUSY_TIMEOUT != 0) && (busy_cnt_q == C_BUSY_LAST);
    // Any driver other than the pointed-to requester is a violation, which
    // also covers several drivers at once.
    assign w_proto_bad = (|(driving_interface & ~(C_ONE << ptr_q)))
                       | (|(driving_interface & (driving_interface - C_ONE)));

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        my_turn_d     = my_turn_q;
        offer_cnt_d   = offer_cnt_q;
        busy_cnt_d    = busy_cnt_q;
        proto_err_d   = proto_err_q | w_proto_bad;
        busy_to_err_d = busy_to_err_q;
        case (state_q)
            IDLE: begin
                state_d     = OFFER;
                my_turn_d   = C_ONE << ptr_q;
                offer_cnt_d = '0;
            end
            OFFER: begin
                if (w_own) begin
                    state_d    = BUSY;
                    my_turn_d  = '0;
                    busy_cnt_d = '0;
                end else if (offer_cnt_q == C_OFFER_LAST) begin
                    state_d   = GUARD;
                    my_turn_d = '0;
                end else begin
                    offer_cnt_d = offer_cnt_q + 8'd1;
                end
            end
            GUARD: begin
                // An engine that saw my_turn on the last offer edge lands here.
                if (w_own) begin
                    state_d    = BUSY;
                    busy_cnt_d = '0;
                end else begin
                    state_d     = OFFER;
                    ptr_d       = w_ptr_next;
                    my_turn_d   = C_ONE << w_ptr_next;
                    offer_cnt_d = '0;
                end
            end
            BUSY: begin
                if (!w_own || w_timeout) begin
                    busy_to_err_d = busy_to_err_q | w_own;
                    state_d       = OFFER;
                    ptr_d         = w_ptr_next;
                    my_turn_d     = C_ONE << w_ptr_next;
                    offer_cnt_d   = '0;
                end else begin
                    busy_cnt_d = busy_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                my_turn_d = '0;
            end
        endcase
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            my_turn_q     <= '0;
            offer_cnt_q   <= '0;
            busy_cnt_q    <= '0;
            proto_err_q   <= 1'b0;
            busy_to_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            my_turn_q     <= my_turn_d;
            offer_cnt_q   <= offer_cnt_d;
            busy_cnt_q    <= busy_cnt_d;
            proto_err_q   <= proto_err_d;
            busy_to_err_q <= busy_to_err_d;
        end
    end

    assign my_turn     = my_turn_q;
    assign owner_idx   = ptr_q;
    assign proto_err   = proto_err_q;
    assign busy_to_err = busy_to_err_q;

    trn_tx_mux #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_mux (
        .en             (state_q != IDLE),
        .sel            (ptr_q),
        .req_td         (req_td),
        .req_trem_n     (req_trem_n),
        .req_tsof_n     (req_tsof_n),
        .req_teof_n     (req_teof_n),
        .req_tsrc_rdy_n (req_tsrc_rdy_n),
        .trn_td         (trn_td),
        .trn_trem_n     (trn_trem_n),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n)
    );

endmodule

`default_nettype wire
